pulse_stretch: RTL
==================

Name: pulse_stretch

Overview:
- Output-side conditioning block. Turns short input events (single-cycle strobes or debounced button levels) into LED blinks a human can see.
- Each input rising edge produces one high pulse of exactly ON_CYCLES, followed by a guaranteed low gap of OFF_CYCLES.
- Events arriving during a blink are queued in a saturating counter, so back-to-back events stay distinguishable as separate blinks.
- Sits between event sources (debounced buttons, status strobes) and board LEDs/indicators.

Parameters:
- ON_CYCLES, 8: high time per blink in clk cycles; must be >= 1 and < 2^CNT_W.
- OFF_CYCLES, 4: enforced low gap after each blink in clk cycles; must be >= 1 and < 2^CNT_W.
- CNT_W, 8: width of the on/off down-counter.
- PEND_W, 3: width of the pending-event counter; maximum queued events is 2^PEND_W-1.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- ev_in  in  1  event input; a level or a strobe; only rising edges count.
- clr_ovf  in  1  synchronous clear of the overflow flag.
- led_out  out  1  stretched output, registered.
- busy  out  1  high whenever state != IDLE.
- pend_cnt  out  PEND_W  number of events queued, not yet started.
- overflow  out  1  sticky flag: an event was dropped because the queue was full.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, ev_d=0, cnt=0, pend_cnt=0, overflow=0, led_out=0, busy=0. Asserting reset mid-blink aborts immediately; no event is retained.
- Edge detect: ev_d <= ev_in every cycle; rise = ev_in & ~ev_d. ev_in held high is a single event.
- States: IDLE, ON, OFF.
- IDLE:
  - Enter ON if rise=1, or if pend_cnt>0 (defensive case; not normally reachable).
  - Entry loads cnt=ON_CYCLES-1 and sets led_out=1 on the same edge.
  - Latency: led_out is high the cycle after the edge that samples the rise.
  - A rise taken in IDLE is consumed directly and does not increment pend_cnt.
- ON:
  - led_out=1. If cnt==0: go to OFF, load cnt=OFF_CYCLES-1, set led_out=0. Otherwise cnt--.
  - led_out is high for exactly ON_CYCLES cycles.
- OFF:
  - led_out=0. If cnt==0 and pend_cnt>0: go to ON, load cnt=ON_CYCLES-1, dec=1. If cnt==0 and pend_cnt==0: go to IDLE. Otherwise cnt--.
  - led_out is low for exactly OFF_CYCLES cycles before the next blink.
- Queue:
  - inc = rise & (state != IDLE). dec as defined in OFF.
  - pend_next = pend_cnt + inc - dec, saturating at 2^PEND_W-1.
  - inc and dec in the same cycle: pend_cnt unchanged, no overflow.
  - inc & ~dec & pend_cnt==max: pend_cnt stays at max, overflow <= 1, event dropped.
- overflow:
  - Sticky. Cleared by clr_ovf=1.
  - If set and clear happen in the same cycle, set wins.
- busy: registered, equals (state != IDLE).
- Timing example: an event arriving in the last OFF cycle restarts ON with no IDLE cycle in between.
- All outputs are registered; there is no combinational path from ev_in to any output.

Decomposition:
- Shared package: state enum (IDLE, ON, OFF) and the default ON/OFF constants used by the board top.
- Natural sub-module: edge_detect (ev_in -> rise, one flop plus AND), reusable by other button consumers.
- Queue counter and FSM stay in pulse_stretch.

Test Plan:
- Reset check: rst_n=0 -> all outputs 0. Release reset, single 1-cycle ev_in at cycle 5 -> led_out high cycles 6..13 (8 cycles), low 14..17, busy drops at cycle 18, pend_cnt stays 0.
- Held level: ev_in high for 50 cycles -> exactly one 8-cycle blink, pend_cnt never nonzero.
- Queuing: 3 strobes 2 cycles apart starting in IDLE -> 3 blinks of 8 high / 4 low, pend_cnt peaks at 2, ends at 0, overflow=0.
- Overflow: 9 strobes during one blink with PEND_W=3 -> pend_cnt saturates at 7, overflow=1. Pulse clr_ovf in the same cycle as a further dropped event -> overflow stays 1; a clr_ovf later -> 0. Exactly 8 blinks total.
- Simultaneous events: strobe lands on the OFF cnt==0 cycle with pend_cnt=1 -> pend_cnt stays 1, and the next ON starts the following cycle.
- Mid-operation reset: assert rst_n=0 asynchronously at cycle 3 of ON with pend_cnt=2 -> led_out, pend_cnt and busy go to 0 at once, and no blinks occur after release.

Source files
------------

// File: rtl/pulse_stretch_pkg.sv
// Shared types and board-level defaults for the LED pulse stretcher.
package pulse_stretch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ON   = 2'd1,
      ST_OFF  = 2'd2
   } state_t;

   // Defaults used by the board top; visible blinks at the demo clock rate.
   localparam int unsigned DEF_ON_CYCLES  = 8;
   localparam int unsigned DEF_OFF_CYCLES = 4;
   localparam int unsigned DEF_CNT_W      = 8;
   localparam int unsigned DEF_PEND_W     = 3;

endpackage : pulse_stretch_pkg

// File: rtl/pulse_stretch_edge_detect.sv
// Rising-edge detector: one history flop; a held-high level yields a single rise.
module pulse_stretch_edge_detect (
   input  logic clk,
   input  logic rst_n,
   input  logic ev_in,
   output logic rise
);

   logic ev_d;

   // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ev_d <= 1'b0;
      else        ev_d <= ev_in;
   end

   assign rise = ev_in & ~ev_d;

endmodule : pulse_stretch_edge_detect

// File: rtl/pulse_stretch.sv
// Stretches input rising edges into ON_CYCLES-high / OFF_CYCLES-low LED blinks,
// queuing events that arrive mid-blink in a saturating pending counter.
module pulse_stretch
   import pulse_stretch_pkg::*;
#(
   parameter int unsigned ON_CYCLES  = DEF_ON_CYCLES,
   parameter int unsigned OFF_CYCLES = DEF_OFF_CYCLES,
   parameter int unsigned CNT_W      = DEF_CNT_W,
   parameter int unsigned PEND_W     = DEF_PEND_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ev_in,
   input  logic              clr_ovf,
   output logic              led_out,
   output logic              busy,
   output logic [PEND_W-1:0] pend_cnt,
   output logic              overflow
);

   localparam logic [CNT_W-1:0]  ON_LOAD  = CNT_W'(ON_CYCLES - 1);
   localparam logic [CNT_W-1:0]  OFF_LOAD = CNT_W'(OFF_CYCLES - 1);
   localparam logic [PEND_W-1:0] PEND_MAX = '1;

   logic              rise;
   state_t            state, state_n;
   logic [CNT_W-1:0]  cnt, cnt_n;
   logic              led_n;
   logic              inc, dec, ovf_set, ovf_n;
   logic [PEND_W-1:0] pend_n;

   pulse_stretch_edge_detect u_edge (
      .clk   (clk),
      .rst_n (rst_n),
      .ev_in (ev_in),
      .rise  (rise)
   );

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      led_n   = 1'b0;
      dec     = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (rise || (pend_cnt != '0)) begin
               state_n = ST_ON;
               cnt_n   = ON_LOAD;
               led_n   = 1'b1;
               dec     = !rise && (pend_cnt != '0);
            end
         end
         ST_ON: begin
            if (cnt == '0) begin
               state_n = ST_OFF;
               cnt_n   = OFF_LOAD;
            end else begin
               led_n = 1'b1;
               cnt_n = cnt - 1'b1;
            end
         end
         ST_OFF: begin
            if (cnt == '0) begin
               // A rise on the last gap cycle chains straight into the next blink;
               // its inc cancels this dec so the queue depth is unchanged.
               if (rise || (pend_cnt != '0)) begin
                  state_n = ST_ON;
                  cnt_n   = ON_LOAD;
                  led_n   = 1'b1;
                  dec     = 1'b1;
               end else begin
                  state_n = ST_IDLE;
               end
            end else begin
               cnt_n = cnt - 1'b1;
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   always_comb begin
      inc     = rise && (state != ST_IDLE);
      pend_n  = pend_cnt;
      ovf_set = 1'b0;
      if (inc && !dec) begin
         if (pend_cnt == PEND_MAX) ovf_set = 1'b1;
         else                      pend_n  = pend_cnt + 1'b1;
      end else if (dec && !inc) begin
         pend_n = pend_cnt - 1'b1;
      end
      ovf_n = ovf_set | (overflow & ~clr_ovf);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         led_out  <= 1'b0;
         busy     <= 1'b0;
         pend_cnt <= '0;
         overflow <= 1'b0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         led_out  <= led_n;
         busy     <= (state_n != ST_IDLE);
         pend_cnt <= pend_n;
         overflow <= ovf_n;
      end
   end

endmodule : pulse_stretch
